// File: rtl/pattern_sequencer.sv
// pattern_sequencer: programmable-rate step generator that advances a 5-bit
// LFSR or one-hot chaser pattern and drives it to the LEDs with 4-level PWM
// brightness, a tick pulse, a wrap pulse and a heartbeat.
//
// io_in : [0] enable, [1] mode (0 LFSR / 1 chaser), [2] chaser dir (0 left /
//         1 right), [4:3] rate, [5] single-step, [7:6] brightness
// io_out: [4:0] gated pattern, [5] tick, [6] wrap, [7] heartbeat
//
// DIV_LOG2 is log2 of the slowest tick period and is meant to lie in 7..20.
// SEED must be non-zero and one-hot so the chaser always shows a single LED.
module pattern_sequencer #(
    parameter int          DIV_LOG2 = 12,
    parameter logic [4:0]  SEED     = 5'b00001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        MODE_LFSR   = 1'b0,
        MODE_CHASER = 1'b1
    } mode_e;

    localparam logic [DIV_LOG2-1:0] CNT_ONES = '1;
    localparam logic [DIV_LOG2-1:0] CNT_ONE  = DIV_LOG2'(1);

    // Two-flop synchronizer for the asynchronous user inputs.
    logic [7:0] sync1;
    logic [7:0] sync2;

    // Registered state.
    logic [DIV_LOG2-1:0] cnt;
    logic [4:0]          p;
    logic [1:0]          w;
    logic                hb;
    logic                step_q;
    mode_e               mode_q;

    // Decoded synced controls.
    logic                en;
    mode_e               mode;
    logic                dir;
    logic [1:0]          rate;
    logic                step;
    logic [1:0]          bright;

    // Next-state values.
    logic [DIV_LOG2-1:0] limit;
    logic                mode_chg;
    logic                due;
    logic                step_tick;
    logic                tick;
    logic                wrap;
    logic                on;
    logic [4:0]          shifted;
    logic [4:0]          p_next;
    logic [DIV_LOG2-1:0] cnt_next;
    logic                hb_next;

    assign en     = sync2[0];
    assign mode   = mode_e'(sync2[1]);
    assign dir    = sync2[2];
    assign rate   = sync2[4:3];
    assign step   = sync2[5];
    assign bright = sync2[7:6];

    // Capture io_in through two flops before any logic looks at it.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge value of its source; = here would collapse sync1/sync2.
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
        end
    end

    // Compute the tick decision, next pattern, next count and output fields.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        limit     = CNT_ONES >> {rate, 1'b0};
        mode_chg  = (mode != mode_q);
        due       = en && (cnt >= limit);
        step_tick = !en && step && !step_q;
        tick      = !mode_chg && (due || step_tick);
        on        = (w <= bright);

        shifted = {p[3:0], p[4] ^ p[2]};
        if (mode == MODE_CHASER) begin
            shifted = dir ? {p[0], p[4:1]} : {p[3:0], p[4]};
        end

        p_next = p;
        if (mode_chg) begin
            p_next = SEED;
        end else if (tick) begin
            p_next = (p == 5'b00000) ? SEED : shifted;
        end

        cnt_next = cnt;
        if (mode_chg) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = due ? '0 : cnt + CNT_ONE;
        end

        wrap    = tick && (p_next == SEED);
        hb_next = hb ^ tick;
    end

    // Update sequencer state and register every io_out bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            p      <= SEED;
            w      <= 2'd0;
            hb     <= 1'b0;
            step_q <= 1'b0;
            mode_q <= MODE_LFSR;
            io_out <= 8'h00;
        end else begin
            cnt    <= cnt_next;
            p      <= p_next;
            w      <= w + 2'd1;
            hb     <= hb_next;
            step_q <= step;
            mode_q <= mode;
            io_out <= {hb_next, wrap, tick, p_next & {5{on}}};
        end
    end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Downstream consumer of the ripple-divider and shift-register stage. It produces a slow step tick from `clk` with a fully synchronous, programmable prescaler. On each tick it advances a 5-bit display pattern, either a maximal-length LFSR or a one-hot chaser, and drives it to the LEDs on `io_out` with 4-level PWM brightness plus status pulses. It runs standalone behind the usual 8-in/8-out user-module pinout.

## Interface
- `DIV_LOG2`, default 12: log2 of the slowest tick period in clocks. Legal range 7..20.
- `SEED`, default 5'b00001: pattern loaded on reset and on mode change. Must be non-zero and one-hot.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `io_in`, input, 8:
  - [0] enable
  - [1] mode (0 = LFSR, 1 = chaser)
  - [2] chaser direction (0 = left, 1 = right)
  - [4:3] rate
  - [5] single-step
  - [7:6] brightness
- `io_out`, output, 8:
  - [4:0] gated pattern
  - [5] tick pulse
  - [6] wrap pulse
  - [7] heartbeat

## Operation
- Input sync: all of `io_in` passes through a 2-flop synchronizer, reset to 0. Every control below uses the synced copy.
- Prescaler:
  - Counter width is `DIV_LOG2`. It counts while enable = 1 and holds its value while enable = 0.
  - Period P = 2^(`DIV_LOG2` − 2·rate). With the default this gives 4096, 1024, 256, 64.
  - Tick fires when count ≥ P−1; the count then returns to 0.
  - The ≥ compare means a rate change to a shorter period mid-count ticks on the next enabled cycle.
- Step:
  - A rising edge on synced step while enable = 0 produces exactly one tick.
  - Step is ignored while enable = 1.
- Pattern update on tick:
  - LFSR mode: p ← {p[3:0], p[4]^p[2]}, period 31.
  - Chaser left: p ← {p[3:0], p[4]}.
  - Chaser right: p ← {p[0], p[4:1]}, period 5.
- Lockup guard: if p = 0 at a tick, it loads `SEED` instead of shifting.
- Mode change: when synced mode differs from its registered copy, p ← `SEED` and the prescaler clears to 0 in that cycle. No tick is generated that cycle, even if one was due.
- Wrap: asserted on a tick whose next p equals `SEED`.
- Heartbeat: toggles on every tick.
- PWM:
  - 2-bit free-running counter w, running even while disabled.
  - LEDs are on when w ≤ brightness, giving 25/50/75/100 % duty.
  - `io_out`[4:0] = p & {5{on}}.
- Outputs: all `io_out` bits are registered, with no combinational path from `io_in`.

## Timing
- Reset values:
  - p = `SEED`, prescaler = 0, w = 0, heartbeat = 0, sync flops = 0.
  - All `io_out` = 0 in every cycle that `reset` is high.
  - First cycle after release: `io_out`[4:0] = `SEED` (w = 0, brightness 0 means on), `io_out`[7:5] = 0.
- Input latency: an `io_in` change is first used by logic 2 clocks later. Its effect on `io_out` appears 3 clocks after the input edge.
- Tick timing:
  - The tick cycle updates p, heartbeat, tick and wrap together.
  - `io_out`[5] is high for exactly 1 clock, in the same cycle the new pattern appears.
  - Consecutive ticks are exactly P clocks apart.
- Wrap pulse coincides with the tick pulse.
- Enable low: the prescaler freezes. Re-enabling resumes from the held count, so no partial period is lost or restarted.
- Simultaneous events:
  - reset has priority over everything.
  - Mode change beats tick.
  - Step while enable = 1 is ignored.
- Reset mid-period: the prescaler and pattern restart from their reset values. The next tick comes P clocks after release plus the sync delay of enable.

## Test plan
- Reset, enable = 1, rate = 3, mode = LFSR, brightness = 3:
  - Ticks every 64 clocks.
  - `io_out`[4:0] sequence: 00001, 00010, 00100, 01001, 10010, 00101, 01011.
  - The wrap pulse recurs on tick 31, 62, and so on.
- Chaser:
  - mode = 1, dir = 0 from `SEED`: 00010, 00100, 01000, 10000, 00001, with wrap on the 5th tick.
  - dir = 1: 10000, 01000, and onward.
- enable = 0 with three step pulses 10 clocks apart: exactly 3 single-clock ticks and 3 pattern advances. A held-high step gives only 1 tick.
- Rate change from 0 to 3 at prescaler count 1000: tick on the first cycle the new rate is applied, then 64-clock spacing.
- Brightness sweep 0..3 with a static pattern: `io_out`[0] high in 1, 2, 3, 4 of every 4 clocks respectively.
- Mode toggle mid-sequence (p = 01011): p returns to 00001 and the prescaler clears. Assert reset during the 3rd tick period: all `io_out` = 0 during reset, then `SEED` pattern with no tick before 64 clocks elapse.
